// File: rtl/fpu_issue.sv
// Request sequencer in front of the fpu: buffers operations in a small FIFO,
// issues them one at a time, and answers division locally with a quiet NaN.
module fpu_issue #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int N             = Mantissa_Size + Exponent_Size,
    parameter int Depth         = 4,
    parameter int Timeout       = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N:0]   req_a,
    input  logic [N:0]   req_b,
    output logic         fpu_load,
    output logic         fpu_enable,
    output logic [1:0]   fpu_op,
    output logic [N:0]   fpu_a,
    output logic [N:0]   fpu_b,
    input  logic         fpu_done,
    input  logic         fpu_zero,
    input  logic         fpu_overflow,
    input  logic         fpu_underflow,
    input  logic         fpu_nan,
    input  logic [N:0]   fpu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_op,
    output logic [N:0]   rsp_result,
    output logic         rsp_zero,
    output logic         rsp_overflow,
    output logic         rsp_underflow,
    output logic         rsp_nan,
    output logic         rsp_timeout
);
    localparam int AW = $clog2(Depth);
    localparam int TW = $clog2(Timeout) + 1;
    localparam int EW = 2 + 2 * (N + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(Depth);
    localparam logic [TW-1:0] T_LAST = TW'(Timeout - 1);
    localparam logic [1:0]    OP_DIV = 2'b11;
    localparam logic [N:0]    QNAN   = {1'b0, {Exponent_Size{1'b1}}, 1'b1, {(Mantissa_Size - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t        state, state_nx;
    logic [EW-1:0] mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ready_en;
    logic          push, pop;
    logic [1:0]    head_op;
    logic [N:0]    head_a, head_b;
    logic [1:0]    op_q;
    logic [N:0]    a_q, b_q;
    logic [TW-1:0] tcnt;
    logic          done_ok, expired;
    logic [N:0]    result_q;
    logic          zero_q, overflow_q, underflow_q, nan_q, timeout_q;

    assign {head_op, head_a, head_b} = mem[rd_ptr];
    // ready_en keeps req_ready low in the cycle right after a reset edge
    assign req_ready = ready_en && (count != FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    // done seen in the first RUN cycle may belong to the previous operation
    assign done_ok   = fpu_done && (tcnt != '0);
    assign expired   = (tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_op, req_a, req_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = (head_op == OP_DIV) ? HOLD : LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (done_ok || expired) state_nx = HOLD;
            HOLD:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fpu_load   = (state == LOAD);
        fpu_enable = (state == RUN);
        rsp_valid  = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tcnt        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            nan_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (pop) begin
                op_q <= head_op;
                a_q  <= head_a;
                b_q  <= head_b;
                if (head_op == OP_DIV) begin
                    result_q    <= QNAN;
                    zero_q      <= 1'b0;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                    nan_q       <= 1'b1;
                    timeout_q   <= 1'b0;
                end
            end
            if (state == LOAD) begin
                tcnt <= '0;
            end else if (state == RUN) begin
                tcnt <= tcnt + 1'b1;
            end
            if (state == RUN) begin
                if (done_ok) begin
                    result_q    <= fpu_result;
                    zero_q      <= fpu_zero;
                    overflow_q  <= fpu_overflow;
                    underflow_q <= fpu_underflow;
                    nan_q       <= fpu_nan;
                    timeout_q   <= 1'b0;
                end else if (expired) begin
                    result_q    <= '0;
                    zero_q      <= 1'b0;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                    nan_q       <= 1'b0;
                    timeout_q   <= 1'b1;
                end
            end
        end
    end

    assign fpu_op        = op_q;
    assign fpu_a         = a_q;
    assign fpu_b         = b_q;
    assign rsp_op        = op_q;
    assign rsp_result    = result_q;
    assign rsp_zero      = zero_q;
    assign rsp_overflow  = overflow_q;
    assign rsp_underflow = underflow_q;
    assign rsp_nan       = nan_q;
    assign rsp_timeout   = timeout_q;
endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: an fpu stand-in, a queue-based reference model checked
// every cycle, and directed scenarios with hand-computed literals.
module tb_fpu_issue;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        fpu_load, fpu_enable;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_done = 1'b0, fpu_zero = 1'b0, fpu_overflow = 1'b0;
    logic        fpu_underflow = 1'b0, fpu_nan = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_underflow, rsp_nan, rsp_timeout;

    fpu_issue #(.Mantissa_Size(23), .Exponent_Size(8), .Depth(4), .Timeout(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .fpu_load(fpu_load), .fpu_enable(fpu_enable),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_zero(fpu_zero), .fpu_overflow(fpu_overflow),
        .fpu_underflow(fpu_underflow), .fpu_nan(fpu_nan), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .rsp_nan(rsp_nan), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          to;
    } req_t;

    req_t exp_q[$];
    req_t iss_q[$];
    req_t cur;
    int   checks = 0, errors = 0;
    int   load_cnt = 0, en_cnt = 0, rsp_cnt = 0, run_cnt = 0;
    bit   stale = 0, tie0 = 0;
    int   lat = 1;
    int   k_run = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behaviour of the downstream fpu as seen by this block
    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a + b + 32'(op);
    endfunction

    function automatic logic [3:0] fpu_flags(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        return {r == 32'h0, a[0], b[0], a[1] ^ b[1]};
    endfunction

    // Expected {result, zero, overflow, underflow, nan, timeout}
    function automatic logic [36:0] expect_rsp(input req_t e);
        logic [31:0] r;
        if (e.op == 2'b11) return {32'h7FC00000, 5'b00010};
        if (e.to) return {32'h0, 5'b00001};
        r = fpu_fn(e.op, e.a, e.b);
        return {r, fpu_flags(e.a, e.b, r), 1'b0};
    endfunction

    // fpu stand-in: done after `lat` RUN cycles past the first, optional stale done
    always @(negedge clk) begin
        if (fpu_load) begin
            k_run = 0;
            fpu_done = stale;
            fpu_result = stale ? 32'hDEADBEEF : 32'h0;
            {fpu_zero, fpu_overflow, fpu_underflow, fpu_nan} = stale ? 4'hF : 4'h0;
        end else if (fpu_enable) begin
            k_run++;
            if (k_run == 1 && stale) begin
                fpu_done = 1'b1;
            end else if (!tie0 && k_run >= 1 + lat) begin
                fpu_done = 1'b1;
                fpu_result = fpu_fn(fpu_op, fpu_a, fpu_b);
                {fpu_zero, fpu_overflow, fpu_underflow, fpu_nan} = fpu_flags(fpu_a, fpu_b, fpu_result);
            end else begin
                fpu_done = 1'b0;
            end
        end
    end

    bit          held = 0;
    logic [38:0] held_val;

    always @(negedge clk) begin
        req_t e;
        if (!rst_n) begin
            exp_q.delete();
            iss_q.delete();
            held = 0;
        end else begin
            if (held) begin
                chk("rsp_stable", {rsp_valid, rsp_op, rsp_result, rsp_zero, rsp_overflow,
                                   rsp_underflow, rsp_nan, rsp_timeout}, {1'b1, held_val});
            end
            if (fpu_load) begin
                load_cnt++;
                run_cnt = 0;
                checks++;
                if (iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue: fpu_load with no pending non-div request");
                end else begin
                    cur = iss_q.pop_front();
                    chk("issue_operands", {fpu_op, fpu_a, fpu_b}, {cur.op, cur.a, cur.b});
                end
            end
            if (fpu_enable) begin
                en_cnt++;
                run_cnt++;
                chk("run_operands", {fpu_op, fpu_a, fpu_b}, {cur.op, cur.a, cur.b});
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rsp: rsp_valid=1 with no outstanding request");
                end else if (rsp_ready) begin
                    e = exp_q.pop_front();
                    rsp_cnt++;
                    chk("rsp_op", rsp_op, e.op);
                    chk("rsp_payload", {rsp_result, rsp_zero, rsp_overflow, rsp_underflow,
                                        rsp_nan, rsp_timeout}, expect_rsp(e));
                    if (e.to) chk("timeout_run_cycles", run_cnt, TO);
                end
            end
            held = rsp_valid && !rsp_ready;
            held_val = {rsp_op, rsp_result, rsp_zero, rsp_overflow, rsp_underflow, rsp_nan, rsp_timeout};
            if (req_valid && req_ready) begin
                e.op = req_op; e.a = req_a; e.b = req_b; e.to = tie0;
                exp_q.push_back(e);
                if (req_op != 2'b11) iss_q.push_back(e);
            end
        end
    end

    // All driver tasks start and end at 1 time unit after a rising edge
    task automatic push_try(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output bit acc);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        acc = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc = 0;
        for (int i = 0; i < 200 && !acc; i++) push_try(op, a, b, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push: request not accepted within 200 cycles");
        end
    endtask

    // k = edges after the acceptance edge until rsp_valid is seen high
    task automatic wait_valid(input int maxc, output int k);
        k = 0;
        while (!rsp_valid && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL wait_valid: no rsp_valid after %0d cycles", maxc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {fpu_load, fpu_enable, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_op, rsp_result,
                              rsp_zero, rsp_overflow, rsp_underflow, rsp_nan, rsp_timeout}, '0);
        chk("reset_req_ready", req_ready, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready_after_reset", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lc, ec, base;
        bit acc;
        bit [5:0] acc_pat;
        logic [1:0] ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

        do_reset();

        // add: 1.5 + 2.25 = 3.75, minimum latency
        lc = load_cnt;
        push(2'b00, 32'h3FC00000, 32'h40100000);
        wait_valid(20, k);
        chk("add_latency", k, 4);
        chk("add_result", rsp_result, 32'h40700000);
        chk("add_op", rsp_op, 2'b00);
        chk("add_flags", {rsp_zero, rsp_overflow, rsp_underflow, rsp_nan, rsp_timeout}, 5'b0);
        chk("add_load_pulses", load_cnt - lc, 1);
        @(posedge clk); #1;

        // mul 2*3 = 6 with a stale done in LOAD and the first RUN cycle
        stale = 1;
        push(2'b10, 32'h40000000, 32'h40400000);
        wait_valid(20, k);
        chk("mul_result", rsp_result, 32'h40C00000);
        chk("mul_op", rsp_op, 2'b10);
        @(posedge clk); #1;
        stale = 0;

        // div is answered locally
        lc = load_cnt; ec = en_cnt;
        push(2'b11, 32'h12345678, 32'h9ABCDEF0);
        wait_valid(10, k);
        chk("div_latency", k, 1);
        chk("div_result", rsp_result, 32'h7FC00000);
        chk("div_flags", {rsp_zero, rsp_overflow, rsp_underflow, rsp_nan, rsp_timeout}, 5'b00010);
        chk("div_op", rsp_op, 2'b11);
        @(posedge clk); #1;
        chk("div_no_fpu_activity", {load_cnt - lc, en_cnt - ec}, 64'h0);

        // FIFO full and wrap: 1 in HOLD plus 4 buffered, sixth refused
        rsp_ready = 1'b0;
        base = rsp_cnt;
        acc_pat = '0;
        for (int i = 0; i < 6; i++) begin
            push_try(ops[i], 32'h10000000 + 32'(i * 32'h111), 32'h00000100 + 32'(i * 3), acc);
            acc_pat[i] = acc;
        end
        chk("full_accept_pattern", acc_pat, 6'b011111);
        chk("full_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && rsp_cnt - base < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("full_drain_count", rsp_cnt - base, 5);
        chk("full_req_ready_after", req_ready, 1'b1);

        // timeout: done never arrives
        tie0 = 1;
        push(2'b00, 32'h3F800000, 32'h3F800000);
        wait_valid(100, k);
        chk("timeout_latency", k, TO + 2);
        chk("timeout_flag", rsp_timeout, 1'b1);
        chk("timeout_result", rsp_result, 32'h0);
        @(posedge clk); #1;
        tie0 = 0;
        push(2'b01, 32'h00000005, 32'h00000002);
        wait_valid(20, k);
        chk("after_timeout_latency", k, 4);
        @(posedge clk); #1;

        // reset during RUN with two requests queued
        tie0 = 1;
        push(2'b00, 32'h11111111, 32'h22222222);
        push(2'b01, 32'h33333333, 32'h44444444);
        push(2'b10, 32'h55555555, 32'h66666666);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_in_run", fpu_enable, 1'b1);
        do_reset();
        tie0 = 0;
        repeat (10) begin @(posedge clk); #1; end
        chk("no_rsp_after_reset", {rsp_valid, fpu_load, fpu_enable}, 3'b000);
        push(2'b10, 32'h40000000, 32'h40400000);
        wait_valid(20, k);
        chk("fresh_latency", k, 4);
        chk("fresh_result", rsp_result, 32'h40C00000);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
